// File: rtl/sram_req_adapter.sv
// sram_req_adapter: req/gnt to active-low SRAM controls, with a response buffer absorbing read latency.
// Optional SRAM_INIT_EN: zero-fill the whole memory after reset before granting requests.
module sram_req_adapter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [BE_WIDTH-1:0]   be_i,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  init_done_o,
    output logic                  sram_initn_o,
    output logic                  sram_cen_o,
    output logic [ADDR_WIDTH-1:0] sram_a_o,
    output logic                  sram_wen_o,
    output logic [DATA_WIDTH-1:0] sram_d_o,
    output logic [BE_WIDTH-1:0]   sram_ben_o,
    input  logic [DATA_WIDTH-1:0] sram_q_i
);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_buf [RSP_DEPTH];
    logic [PW-1:0]         r_rptr;
    logic [PW-1:0]         r_wptr;
    logic [CW-1:0]         r_count;
    logic                  r_inflight;
    logic [CW:0]           w_outstanding;
    logic                  w_acc;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_init_done;
    logic                  w_initn;
    logic                  w_init_wr;
    logic [ADDR_WIDTH-1:0] w_init_addr;

`ifdef SRAM_INIT_EN
    typedef enum logic [1:0] {S_IDLE, S_INIT, S_DONE} state_t;
    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_init_addr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_init_addr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_addr <= (r_state == S_INIT) ? r_init_addr + 1'b1 : '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_INIT;
            S_INIT:  w_state_nxt = (r_init_addr == '1) ? S_DONE : S_INIT;
            default: w_state_nxt = S_DONE;
        endcase
    end

    assign w_init_done = (r_state == S_DONE);
    assign w_initn     = (r_state != S_IDLE);
    assign w_init_wr   = (r_state == S_INIT);
    assign w_init_addr = r_init_addr;
`else
    logic r_init_done;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_init_done <= 1'b0;
        else         r_init_done <= 1'b1;
    end

    assign w_init_done = r_init_done;
    assign w_initn     = r_init_done;
    assign w_init_wr   = 1'b0;
    assign w_init_addr = '0;
`endif

    // Reads need a free buffer slot for every response still owed, including the one in the macro.
    assign w_outstanding = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign gnt_o         = req_i & w_init_done & (we_i | (w_outstanding < (CW+1)'(RSP_DEPTH)));
    assign w_acc         = req_i & gnt_o;
    assign init_done_o   = w_init_done;
    assign sram_initn_o  = w_initn;

    always_comb begin
        sram_cen_o = 1'b1;
        sram_wen_o = 1'b1;
        sram_ben_o = '1;
        sram_a_o   = '0;
        sram_d_o   = '0;
        if (w_init_wr) begin
            sram_cen_o = 1'b0;
            sram_wen_o = 1'b0;
            sram_ben_o = '0;
            sram_a_o   = w_init_addr;
        end else if (w_acc) begin
            sram_cen_o = 1'b0;
            sram_wen_o = ~we_i;
            sram_ben_o = ~be_i;
            sram_a_o   = addr_i;
            sram_d_o   = wdata_i;
        end
    end

    // Macro data bypasses the buffer only when nothing older is queued and the consumer takes it now.
    assign w_push   = r_inflight & ((r_count != '0) | ~rready_i);
    assign w_pop    = (r_count != '0) & rready_i;
    assign rvalid_o = (r_count != '0) | r_inflight;
    assign rdata_o  = (r_count != '0) ? r_buf[r_rptr] : sram_q_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RSP_DEPTH; i++) r_buf[i] <= '0;
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_acc & ~we_i;
            r_count    <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_push) begin
                r_buf[r_wptr] <= sram_q_i;
                r_wptr        <= (r_wptr == PW'(RSP_DEPTH - 1)) ? '0 : r_wptr + PW'(1);
            end
            if (w_pop) r_rptr <= (r_rptr == PW'(RSP_DEPTH - 1)) ? '0 : r_rptr + PW'(1);
        end
    end
endmodule

// File: tb/tb_sram_req_adapter.sv
// tb_sram_req_adapter: random and directed traffic against a queue-based reference model and an SRAM model.
module tb_sram_req_adapter;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int BW    = 4;
    localparam int DEPTH = 2;
`ifdef SRAM_INIT_EN
    localparam int LAT = 1 + (1 << AW);
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [BW-1:0] be = '0;
    logic          rready = 1'b1;
    logic          gnt, rvalid, init_done, initn, cen, wen;
    logic [DW-1:0] rdata, sram_d, sram_q;
    logic [AW-1:0] sram_a;
    logic [BW-1:0] ben;

    int total = 0;
    int bad = 0;
    int cyc;
    logic [DW-1:0] mem [1 << AW];
    logic [DW-1:0] shadow [1 << AW];
    logic [DW-1:0] expq [$];
    logic m_done, m_gnt;

    sram_req_adapter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .RSP_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata),
        .init_done_o(init_done), .sram_initn_o(initn), .sram_cen_o(cen), .sram_a_o(sram_a),
        .sram_wen_o(wen), .sram_d_o(sram_d), .sram_ben_o(ben), .sram_q_i(sram_q)
    );

    always #5 clk = ~clk;

    // Single-port macro with registered read data.
    always @(posedge clk) begin
        if (!cen) begin
            if (!wen) begin
                for (int b = 0; b < BW; b++) if (!ben[b]) mem[sram_a][8*b +: 8] <= sram_d[8*b +: 8];
            end else begin
                sram_q <= mem[sram_a];
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: every response owed is a queue entry holding the word the address held when the read was accepted.
    always @(negedge clk) begin
        if (rst_n) begin
            m_done = (cyc >= LAT);
`ifdef SRAM_INIT_EN
            if (cyc == LAT) for (int i = 0; i < (1 << AW); i++) shadow[i] = '0;
`endif
            chk("init_done", {63'd0, init_done}, {63'd0, m_done});
            chk("initn", {63'd0, initn}, {63'd0, cyc >= 1});
            m_gnt = req & m_done & (we | (expq.size() < DEPTH));
            chk("gnt", {63'd0, gnt}, {63'd0, m_gnt});
            chk("rvalid", {63'd0, rvalid}, {63'd0, expq.size() != 0});
            if (rvalid && expq.size() != 0) begin
                chk("rdata", {32'd0, rdata}, {32'd0, expq[0]});
                if (rready) void'(expq.pop_front());
            end
            if (req && gnt) begin
                chk("sram_req", {cen, wen, ben, sram_a, sram_d}, {1'b0, ~we, ~be, addr, (we ? wdata : sram_d)});
                if (we) begin
                    for (int b = 0; b < BW; b++) if (be[b]) shadow[addr][8*b +: 8] = wdata[8*b +: 8];
                    chk("sram_d", {32'd0, sram_d}, {32'd0, wdata});
                end else begin
                    expq.push_back(shadow[addr]);
                end
            end else if (m_done) begin
                chk("sram_idle", {58'd0, cen, wen, ben}, {58'd0, 1'b1, 1'b1, {BW{1'b1}}});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] b);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        #1;
        for (int n = 0; n < 50; n++) begin
            if (gnt) break;
            step();
        end
        if (!gnt) chk("grant_timeout", 64'd0, 64'd1);
        step();
        req = 1'b0;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 100; n++) begin
            if (init_done) break;
            step();
        end
        chk("init_wait", {63'd0, init_done}, 64'd1);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]    = $urandom;
            shadow[i] = mem[i];
        end
        req = 1'b1;
        #23;
        chk("rst_gnt", {63'd0, gnt}, 64'd0);
        chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
        chk("rst_done", {62'd0, init_done, initn}, 64'd0);
        chk("rst_sram", {cen, wen, ben, sram_a, sram_d}, {1'b1, 1'b1, {BW{1'b1}}, {AW{1'b0}}, {DW{1'b0}}});
        req = 1'b0;
        step();
        rst_n = 1'b1;
        wait_done();
        step();

        do_req(1'b1, 4'h5, 32'hDEADBEEF, 4'hF);
        do_req(1'b0, 4'h5, 32'h0, 4'h0);
        chk("rd_lat_valid", {63'd0, rvalid}, 64'd1);
        chk("rd_lat_data", {32'd0, rdata}, 64'h0000_0000_DEAD_BEEF);
        step();

        do_req(1'b1, 4'h7, 32'h11223344, 4'hF);
        do_req(1'b1, 4'h7, 32'hAABBCCDD, 4'h5);
        do_req(1'b0, 4'h7, 32'h0, 4'h0);
        chk("be_merge", {32'd0, rdata}, 64'h0000_0000_11BB_33DD);
        step();

        for (int i = 1; i <= 4; i++) do_req(1'b1, AW'(i), 32'h100 + i, 4'hF);
        req = 1'b1; we = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            addr = AW'(i);
            #1;
            chk("b2b_gnt", {63'd0, gnt}, 64'd1);
            if (i > 1) chk("b2b_data", {31'd0, rvalid, rdata}, {31'd0, 1'b1, 32'h100 + i - 1});
            step();
        end
        req = 1'b0;
        #1;
        chk("b2b_last", {31'd0, rvalid, rdata}, {31'd0, 1'b1, 32'h104});
        step();

        rready = 1'b0;
        do_req(1'b0, 4'h1, 32'h0, 4'h0);
        do_req(1'b0, 4'h2, 32'h0, 4'h0);
        req = 1'b1; we = 1'b0; addr = 4'h3;
        #1;
        chk("bp_gnt0", {31'd0, gnt, rdata}, {31'd0, 1'b0, 32'h101});
        step();
        chk("bp_hold", {30'd0, gnt, rvalid, rdata}, {30'd0, 1'b0, 1'b1, 32'h101});
        rready = 1'b1;
        #1;
        chk("bp_pop1", {31'd0, gnt, rdata}, {31'd0, 1'b0, 32'h101});
        step();
        chk("bp_pop2", {31'd0, gnt, rdata}, {31'd0, 1'b1, 32'h102});
        step();
        req = 1'b0;
        chk("bp_third", {32'd0, rdata}, {32'd0, 32'h103});
        step();

        rready = 1'b0;
        do_req(1'b0, 4'h4, 32'h0, 4'h0);
        do_req(1'b0, 4'h5, 32'h0, 4'h0);
        req = 1'b1; we = 1'b0; addr = 4'h6;
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst", {61'd0, rvalid, cen, gnt}, {61'd0, 1'b0, 1'b1, 1'b0});
        expq.delete();
        req = 1'b0;
        rready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        wait_done();
        repeat (4) step();

        for (int n = 0; n < 800; n++) begin
            req    = ($urandom_range(3) != 0);
            we     = ($urandom_range(2) == 0);
            addr   = AW'($urandom);
            wdata  = $urandom;
            be     = BW'($urandom);
            rready = ($urandom_range(3) != 0);
            step();
        end
        req = 1'b0;
        rready = 1'b1;
        repeat (6) step();
        chk("drained", {63'd0, rvalid}, 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_req_adapter.md
Name: sram_req_adapter

Overview:
- Front-end for generic_memory; sits directly upstream of it.
- Converts an active-high req/gnt request port into the macro's active-low CEN/WEN/BEN controls.
- Absorbs the macro's 1-cycle registered read latency into a small response buffer, so the consumer can apply backpressure on read data without losing any.
- Used wherever a core-side master (cache refill, scratchpad port) drives a single-port SRAM.

Parameters:
- ADDR_WIDTH, 12, word address width; must match the memory instance.
- DATA_WIDTH, 32, data width in bits; must be a multiple of 8.
- BE_WIDTH, DATA_WIDTH/8, number of byte enables.
- RSP_DEPTH, 2, response buffer entries; minimum 2 for full read throughput.

Ports:
- clk_i  in  1  clock; everything is posedge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  1  request valid.
- gnt_o  out  1  request accepted this cycle.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  ADDR_WIDTH  word address.
- wdata_i  in  DATA_WIDTH  write data.
- be_i  in  BE_WIDTH  byte enables, active-high.
- rvalid_o  out  1  read data valid.
- rready_i  in  1  consumer accepts read data.
- rdata_o  out  DATA_WIDTH  read data.
- init_done_o  out  1  adapter ready to take requests.
- sram_initn_o  out  1  to memory INITN.
- sram_cen_o  out  1  to memory CEN, active-low.
- sram_a_o  out  ADDR_WIDTH  to memory A.
- sram_wen_o  out  1  to memory WEN, 0 = write.
- sram_d_o  out  DATA_WIDTH  to memory D.
- sram_ben_o  out  BE_WIDTH  to memory BEN, active-low.
- sram_q_i  in  DATA_WIDTH  from memory Q.

Behaviour:
- Reset values: gnt_o=0, rvalid_o=0, init_done_o=0, sram_initn_o=0, sram_cen_o=1, sram_wen_o=1, sram_ben_o all 1s, sram_a_o=0, sram_d_o=0.
  - Response buffer, occupancy count and in-flight flag are all cleared.
- First clock edge after reset release: sram_initn_o and init_done_o are set to 1.
  - When SRAM_INIT_EN is defined, they are set when the init sequence finishes instead (see Optional Feature).
- Grant, combinational:
  - gnt_o = req_i & init_done_o & (we_i | (count + inflight < RSP_DEPTH)).
  - A write is always granted once init is done.
- Accepted request (req_i & gnt_o) is driven to the SRAM in the same cycle, so the memory samples it at the next edge:
  - sram_cen_o=0, sram_wen_o=~we_i, sram_a_o=addr_i, sram_d_o=wdata_i, sram_ben_o=~be_i.
  - No request: sram_cen_o=1, sram_wen_o=1, sram_ben_o all 1s.
- inflight is a register, set on the edge that accepts a read; sram_q_i is valid the cycle after that edge.
- Read data path:
  - rvalid_o = (count != 0) | inflight.
  - rdata_o = buffer head when count != 0, otherwise sram_q_i (bypass).
  - Read latency is 1 cycle: granted in cycle N, rvalid_o high in N+1 when the buffer is empty.
- Buffer update each cycle:
  - If inflight and (count != 0 or !rready_i), push sram_q_i.
  - If count != 0 and rready_i, pop the head.
  - Push and pop in the same cycle leave count unchanged.
  - Read pointer and write pointer wrap modulo RSP_DEPTH.
- Ordering: responses come out in request order. Writes produce no response.
- rvalid_o/rdata_o stay stable while rvalid_o & !rready_i.
- The credit rule guarantees no overflow; popping the buffer when empty never happens.
- Throughput: with rready_i held high, back-to-back reads run at 1 per cycle.
- Reset mid-operation: in-flight read data is discarded and the buffer is emptied; the SRAM side returns to idle asynchronously.

Optional Feature:
- Macro: SRAM_INIT_EN.
- Defined: after reset release, an init FSM runs INIT → DONE.
  - INIT writes zero to addresses 0 to 2**ADDR_WIDTH-1, one per cycle: sram_cen_o=0, sram_wen_o=0, sram_ben_o all 0s, sram_d_o=0, with sram_initn_o=1 for the whole sequence.
  - gnt_o=0 and init_done_o=0 throughout INIT.
  - init_done_o rises the cycle after the last address is written.
  - Reset during INIT restarts the sequence from address 0.
- Undefined: no FSM; init_done_o and sram_initn_o go to 1 on the first edge after reset.

Test Plan:
- Write addr 0x005, wdata 0xDEADBEEF, be 0xF, then read 0x005 with rready_i=1 → rvalid_o 1 cycle after the read grant, rdata_o=0xDEADBEEF.
- Write 0x11223344 be 0xF, then write 0xAABBCCDD be 0x5 to the same address, then read → 0x11BB33DD.
- Reads of addresses 1,2,3,4 back-to-back, rready_i=1 → gnt_o high for 4 consecutive cycles; 4 consecutive rvalid_o beats, data in order.
- Two reads granted, rready_i=0 → third read gets gnt_o=0; rvalid_o held with the first data. Raise rready_i → both data words delivered in order, third read then granted.
- Assert rst_ni=0 while one read is in flight and one is buffered → rvalid_o=0, sram_cen_o=1 immediately; after release, no stale data appears.
- With SRAM_INIT_EN and ADDR_WIDTH=4 → 16 write cycles with gnt_o=0, then init_done_o=1; a read of any address returns 0x00000000.
